// File: rtl/cordic_uart_pkg.sv
// Shared types and constants for the UART command path feeding the CORDIC request queue.
// Holds the deframer state/error encodings, opcode constants and the checksum fold helper.
package cordic_uart_pkg;

    typedef enum logic [2:0] {
        S_HUNT    = 3'd0,
        S_OPCODE  = 3'd1,
        S_PAYLOAD = 3'd2,
        S_CHECK   = 3'd3,
        S_HOLD    = 3'd4
    } deframe_state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_CHECKSUM = 2'd1,
        ERR_TIMEOUT  = 2'd2,
        ERR_PARITY   = 2'd3
    } frame_err_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // Opcodes are passed through unvalidated; listed for the downstream decoder.
    localparam logic [7:0] OP_ROTATE = 8'h01;
    localparam logic [7:0] OP_VECTOR = 8'h02;

    function automatic logic [7:0] chk_fold(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction

endpackage

// File: rtl/uart_gap_timer.sv
// Inter-byte gap counter: counts idle cycles while running and flags expiry
// once TIMEOUT_CYCLES-1 idle cycles have elapsed since the last clear.
module uart_gap_timer #(
    parameter int TIMEOUT_CYCLES = 10_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clear,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    // Idle-cycle counter; saturates at LAST so expiry stays asserted until the FSM reacts.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= {CW{1'b0}};
        end else if (clear || !run) begin
            count <= {CW{1'b0}};
        end else if (count != LAST) begin
            count <= count + CW'(1'b1);
        end else begin
            count <= count;
        end
    end

    assign expired = run && (count == LAST);

endmodule

// File: rtl/uart_cmd_deframer.sv
// Assembles SYNC/OPCODE/PAYLOAD/CHECKSUM frames from the UART byte stream, verifies the
// XOR checksum and offers each good command to the CORDIC path over valid/ready.
module uart_cmd_deframer
    import cordic_uart_pkg::*;
#(
    parameter int         CLK_FREQ_HZ    = 100_000_000,
    parameter int         PAYLOAD_BYTES  = 4,
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 10_000
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [7:0]                 i_rx_byte,
    input  logic                       i_rx_byte_valid,
    input  logic                       i_rx_err,
    output logic [7:0]                 o_cmd_opcode,
    output logic [8*PAYLOAD_BYTES-1:0] o_cmd_payload,
    output logic                       o_cmd_valid,
    input  logic                       i_cmd_ready,
    output logic                       o_frame_err,
    output logic [1:0]                 o_err_code,
    output logic                       o_drop
);

    localparam int IDX_W = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_BYTES - 1);

    if ((PAYLOAD_BYTES < 1) || (PAYLOAD_BYTES > 8) || (TIMEOUT_CYCLES < 2) || (CLK_FREQ_HZ < 1)) begin : g_param_check
        $error("uart_cmd_deframer: illegal parameter value");
    end

    deframe_state_t             state, state_next;
    logic [IDX_W-1:0]           idx, idx_next;
    logic [7:0]                 chk, chk_next;
    logic [7:0]                 opcode, opcode_next;
    logic [8*PAYLOAD_BYTES-1:0] payload, payload_next;
    logic                       cmd_valid, cmd_valid_next;
    logic                       frame_err, frame_err_next;
    logic                       drop, drop_next;
    frame_err_t                 err_code, err_code_next;
    logic                       timed;
    logic                       expired;

    assign timed = (state == S_OPCODE) || (state == S_PAYLOAD) || (state == S_CHECK);

    uart_gap_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_gap_timer (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .run    (timed),
        .clear  (i_rx_byte_valid),
        .expired(expired)
    );

    // Next-state and next-output logic; inside a frame, parity error beats a byte, a byte beats timeout.
    always_comb begin
        state_next     = state;
        idx_next       = idx;
        chk_next       = chk;
        opcode_next    = opcode;
        payload_next   = payload;
        cmd_valid_next = cmd_valid;
        frame_err_next = 1'b0;
        err_code_next  = err_code;
        drop_next      = 1'b0;
        case (state)
            S_HUNT: begin
                if (i_rx_byte_valid && (i_rx_byte == SYNC_BYTE)) begin
                    state_next = S_OPCODE;
                end else begin
                    state_next = S_HUNT;
                end
            end
            S_OPCODE, S_PAYLOAD, S_CHECK: begin
                if (i_rx_err) begin
                    frame_err_next = 1'b1;
                    err_code_next  = ERR_PARITY;
                    state_next     = S_HUNT;
                end else if (i_rx_byte_valid) begin
                    case (state)
                        S_OPCODE: begin
                            opcode_next = i_rx_byte;
                            chk_next    = i_rx_byte;
                            idx_next    = {IDX_W{1'b0}};
                            state_next  = S_PAYLOAD;
                        end
                        S_PAYLOAD: begin
                            payload_next[{idx, 3'b000} +: 8] = i_rx_byte;
                            chk_next = chk_fold(chk, i_rx_byte);
                            if (idx == LAST_IDX) begin
                                state_next = S_CHECK;
                            end else begin
                                idx_next = idx + IDX_W'(1'b1);
                            end
                        end
                        default: begin
                            if (i_rx_byte == chk) begin
                                state_next     = S_HOLD;
                                cmd_valid_next = 1'b1;
                            end else begin
                                frame_err_next = 1'b1;
                                err_code_next  = ERR_CHECKSUM;
                                state_next     = S_HUNT;
                            end
                        end
                    endcase
                end else if (expired) begin
                    frame_err_next = 1'b1;
                    err_code_next  = ERR_TIMEOUT;
                    state_next     = S_HUNT;
                end else begin
                    state_next = state;
                end
            end
            S_HOLD: begin
                // A byte coinciding with the handshake is judged as a hunt byte, not dropped.
                if (i_cmd_ready) begin
                    cmd_valid_next = 1'b0;
                    if (i_rx_byte_valid && (i_rx_byte == SYNC_BYTE)) begin
                        state_next = S_OPCODE;
                    end else begin
                        state_next = S_HUNT;
                    end
                end else if (i_rx_byte_valid) begin
                    drop_next = 1'b1;
                end else begin
                    state_next = S_HOLD;
                end
            end
            default: begin
                state_next = S_HUNT;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state     <= S_HUNT;
            idx       <= {IDX_W{1'b0}};
            chk       <= 8'h00;
            opcode    <= 8'h00;
            payload   <= {(8*PAYLOAD_BYTES){1'b0}};
            cmd_valid <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= ERR_NONE;
            drop      <= 1'b0;
        end else begin
            state     <= state_next;
            idx       <= idx_next;
            chk       <= chk_next;
            opcode    <= opcode_next;
            payload   <= payload_next;
            cmd_valid <= cmd_valid_next;
            frame_err <= frame_err_next;
            err_code  <= err_code_next;
            drop      <= drop_next;
        end
    end

    assign o_cmd_opcode  = opcode;
    assign o_cmd_payload = payload;
    assign o_cmd_valid   = cmd_valid;
    assign o_frame_err   = frame_err;
    assign o_err_code    = err_code;
    assign o_drop        = drop;

endmodule

// File: tb/tb_uart_cmd_deframer.sv
// Scoreboard bench: a frame-level reference model predicts commands, aborts and drops
// with their cycle; a monitor compares them against whatever the deframer presents.
module tb_uart_cmd_deframer;

    localparam int P = 4;
    localparam int T = 10_000;
    localparam int K_CMD  = 0;
    localparam int K_ERR  = 1;
    localparam int K_DROP = 2;

    typedef struct {
        int          kind;
        int          cyc;
        logic [1:0]  code;
        logic [7:0]  op;
        logic [31:0] pl;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_err = 1'b0;
    logic        rdy = 1'b0;
    logic [7:0]  cmd_opcode;
    logic [31:0] cmd_payload;
    logic        cmd_valid;
    logic        frame_err;
    logic [1:0]  err_code;
    logic        drop;

    int  cyc = 0;
    int  n_checks = 0;
    int  n_errors = 0;
    bit  rand_rdy = 1'b0;
    ev_t exp_q[$];

    bit         m_in_frame = 1'b0;
    bit         m_holding = 1'b0;
    logic [7:0] m_fb[$];
    int         m_last = 0;

    uart_cmd_deframer #(
        .PAYLOAD_BYTES (P),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_rx_byte      (rx_byte),
        .i_rx_byte_valid(rx_valid),
        .i_rx_err       (rx_err),
        .o_cmd_opcode   (cmd_opcode),
        .o_cmd_payload  (cmd_payload),
        .o_cmd_valid    (cmd_valid),
        .i_cmd_ready    (rdy),
        .o_frame_err    (frame_err),
        .o_err_code     (err_code),
        .o_drop         (drop)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void push_ev(int kind, int c, logic [1:0] code, logic [7:0] op, logic [31:0] pl);
        ev_t e;
        e.kind = kind; e.cyc = c; e.code = code; e.op = op; e.pl = pl;
        exp_q.push_back(e);
    endfunction

    // Reference model, one call per clock edge e_cyc with the inputs sampled there.
    function automatic void model_step(int e_cyc, bit v, logic [7:0] b, bit err, bit r);
        logic [7:0]  x;
        logic [31:0] pl;
        if (m_holding) begin
            if (r) begin
                m_holding = 1'b0;
            end else begin
                if (v) push_ev(K_DROP, e_cyc, 2'd0, 8'h00, 32'h0);
                return;
            end
        end
        if (m_in_frame) begin
            if (err) begin
                push_ev(K_ERR, e_cyc, 2'd3, 8'h00, 32'h0);
                m_in_frame = 1'b0;
            end else if (v) begin
                m_fb.push_back(b);
                m_last = e_cyc;
                if (m_fb.size() == P + 2) begin
                    x = 8'h00;
                    for (int i = 0; i <= P; i++) x = x ^ m_fb[i];
                    for (int i = 0; i < P; i++) pl[8*i +: 8] = m_fb[1+i];
                    if (x == m_fb[P+1]) begin
                        push_ev(K_CMD, e_cyc, 2'd0, m_fb[0], pl);
                        m_holding = 1'b1;
                    end else begin
                        push_ev(K_ERR, e_cyc, 2'd1, 8'h00, 32'h0);
                    end
                    m_in_frame = 1'b0;
                end
            end else if (e_cyc - m_last >= T) begin
                push_ev(K_ERR, e_cyc, 2'd2, 8'h00, 32'h0);
                m_in_frame = 1'b0;
            end
            return;
        end
        if (v && (b == 8'hA5)) begin
            m_in_frame = 1'b1;
            m_fb.delete();
            m_last = e_cyc;
        end
    endfunction

    task automatic tick(input bit v, input logic [7:0] b, input bit err);
        @(negedge clk);
        rx_valid = v;
        rx_byte  = v ? b : 8'h00;
        rx_err   = err;
        if (rand_rdy) rdy = 1'($urandom_range(0, 1));
        model_step(cyc + 1, v, b, err, rdy);
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 8'h00, 1'b0);
    endtask

    task automatic send(input logic [7:0] b, input int gap, input bit err);
        idle(gap - 1);
        tick(1'b1, b, err);
    endtask

    // Sends opcode, payload and checksum; err_at names a byte index (1 = opcode) carrying a parity error.
    task automatic send_body(input logic [7:0] op, input logic [31:0] pl, input int gap,
                             input bit bad, input int err_at);
        logic [7:0] c;
        c = op;
        send(op, gap, err_at == 1);
        for (int i = 0; i < P; i++) begin
            c = c ^ pl[8*i +: 8];
            send(pl[8*i +: 8], gap, err_at == 2 + i);
        end
        send(bad ? (c ^ 8'h01) : c, gap, err_at == P + 2);
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [31:0] pl, input int gap,
                              input bit bad, input int err_at);
        send(8'hA5, gap, 1'b0);
        send_body(op, pl, gap, bad, err_at);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_valid"}, cmd_valid, 1'b0);
        chk({tag, "_opcode"}, cmd_opcode, 8'h00);
        chk({tag, "_payload"}, cmd_payload, 32'h0);
        chk({tag, "_frame_err"}, frame_err, 1'b0);
        chk({tag, "_err_code"}, err_code, 2'd0);
        chk({tag, "_drop"}, drop, 1'b0);
    endtask

    task automatic expect_ev(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            chk("unexpected_event", 64'(kind), 64'hFF);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", 64'(kind), 64'(e.kind));
            chk("event_cycle", 64'(cyc), 64'(e.cyc));
            if (kind == K_CMD) begin
                chk("cmd_opcode", cmd_opcode, e.op);
                chk("cmd_payload", cmd_payload, e.pl);
            end else if (kind == K_ERR) begin
                chk("err_code", err_code, e.code);
            end
        end
    endtask

    // Monitor: samples just after each rising edge and matches output events to the scoreboard.
    initial begin
        bit          prev_valid;
        logic [7:0]  held_op;
        logic [31:0] held_pl;
        prev_valid = 1'b0;
        held_op = 8'h00;
        held_pl = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (frame_err === 1'b1) expect_ev(K_ERR);
            if (drop === 1'b1) expect_ev(K_DROP);
            if (cmd_valid === 1'b1 && !prev_valid) begin
                expect_ev(K_CMD);
                held_op = cmd_opcode;
                held_pl = cmd_payload;
            end else if (cmd_valid === 1'b1) begin
                chk("hold_opcode_stable", cmd_opcode, held_op);
                chk("hold_payload_stable", cmd_payload, held_pl);
            end
            prev_valid = (cmd_valid === 1'b1);
        end
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst_n = 1'b1;

        // Good frame, slow byte rate, ready high.
        rdy = 1'b1;
        send_frame(8'h01, 32'h12345678, 50, 1'b0, 0);
        idle(20);

        // Bad checksum, then a good frame.
        send_frame(8'h01, 32'h12345678, 50, 1'b1, 0);
        send_frame(8'h02, 32'hCAFEF00D, 10, 1'b0, 0);
        idle(10);

        // Timeout after a partial frame, then a byte landing exactly on the expiry edge.
        send(8'hA5, 5, 1'b0);
        send(8'h01, 5, 1'b0);
        send(8'h78, 5, 1'b0);
        idle(T + 5);
        send(8'hA5, 5, 1'b0);
        send(8'h01, 5, 1'b0);
        send(8'h78, 5, 1'b0);
        send(8'h56, T, 1'b0);
        send(8'h34, 5, 1'b0);
        send(8'h12, 5, 1'b0);
        send(8'h01 ^ 8'h78 ^ 8'h56 ^ 8'h34 ^ 8'h12, 5, 1'b0);
        idle(10);

        // Parity error on the third payload byte; hunt-state garbage; a good frame.
        send_frame(8'h01, 32'h12345678, 3, 1'b0, 4);
        send(8'h00, 3, 1'b0);
        send(8'hFF, 3, 1'b1);
        send(8'h13, 3, 1'b0);
        send_frame(8'h01, 32'h0BADBEEF, 3, 1'b0, 0);
        idle(10);

        // Backpressure: drops while held, then ready coinciding with a SYNC byte.
        rdy = 1'b0;
        send_frame(8'h02, 32'h89ABCDEF, 4, 1'b0, 0);
        send(8'h11, 5, 1'b0);
        send(8'h22, 5, 1'b0);
        send(8'h33, 5, 1'b0);
        idle(2);
        rdy = 1'b1;
        tick(1'b1, 8'hA5, 1'b0);
        send_body(8'h01, 32'h00C0FFEE, 3, 1'b0, 0);
        idle(10);

        // Reset in the middle of the payload; the rest of that frame is ignored.
        send(8'hA5, 5, 1'b0);
        send(8'h01, 5, 1'b0);
        send(8'h78, 5, 1'b0);
        send(8'h56, 5, 1'b0);
        @(negedge clk);
        rx_valid = 1'b0;
        rx_err = 1'b0;
        rst_n = 1'b0;
        m_in_frame = 1'b0;
        m_holding = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_zero_outputs("mid_reset");
        send(8'h34, 5, 1'b0);
        send(8'h12, 5, 1'b0);
        send(8'h09, 5, 1'b0);
        idle(10);

        // Randomised traffic with corruption and random backpressure.
        rand_rdy = 1'b1;
        for (int n = 0; n < 250; n++) begin
            int          r;
            int          g;
            logic [7:0]  op;
            logic [31:0] pl;
            r  = int'($urandom_range(0, 15));
            g  = int'($urandom_range(1, 4));
            op = 8'($urandom());
            pl = $urandom();
            if (r == 2) begin
                for (int k = 0; k < 3; k++) send(8'($urandom()), g, 1'b0);
            end
            send_frame(op, pl, g, r == 0, (r == 1) ? int'($urandom_range(1, P + 2)) : 0);
            idle(int'($urandom_range(0, 6)));
        end

        rand_rdy = 1'b0;
        rdy = 1'b1;
        idle(30);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
